// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Request FIFO feeding the ALU stage, with a 2-entry tagged result
//            buffer that captures r0 one cycle after each issue.
//            Optional res_zero output: define ALU_ISSUE_ZERO_FLAG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [2:0]      in_op,
    output logic [N-1:0]    alu_r2,
    output logic [N-1:0]    alu_r3,
    output logic [2:0]      alu_op,
    input  logic [N-1:0]    alu_r0,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_data,
    output logic [TAGW-1:0] res_tag,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic            res_zero,
`endif
    output logic            busy
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [N-1:0]    r_fa   [DEPTH];
    logic [N-1:0]    r_fb   [DEPTH];
    logic [2:0]      r_fop  [DEPTH];
    logic [TAGW-1:0] r_ftag [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_cnt;
    logic [TAGW-1:0] r_tag;

    logic            r_pend;
    logic [TAGW-1:0] r_ptag;

    logic [N-1:0]    r_rd [2];
    logic [TAGW-1:0] r_rt [2];
    logic            r_rhead;
    logic [1:0]      r_rcnt;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic            r_rz [2];
`endif

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic [2:0]      w_occ;
    logic            w_widx;

    assign w_empty  = (r_cnt == '0);
    assign in_ready = (r_cnt != c_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = res_valid & res_ready;
    // Occupancy the result buffer will have after this edge; an issue now
    // needs a free slot when its result lands next cycle.
    assign w_occ    = {1'b0, r_rcnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue  = !w_empty && (w_occ <= 3'd1);
    assign w_widx   = r_rhead ^ r_rcnt[0];

    assign alu_r2   = w_empty ? '0 : r_fa[r_rptr];
    assign alu_r3   = w_empty ? '0 : r_fb[r_rptr];
    assign alu_op   = w_empty ? '0 : r_fop[r_rptr];

    assign res_valid = (r_rcnt != 2'd0);
    assign res_data  = res_valid ? r_rd[r_rhead] : '0;
    assign res_tag   = res_valid ? r_rt[r_rhead] : '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign res_zero  = res_valid ? r_rz[r_rhead] : 1'b0;
`endif
    assign busy      = !w_empty || r_pend || res_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fa[i]   <= '0;
                r_fb[i]   <= '0;
                r_fop[i]  <= '0;
                r_ftag[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_tag  <= '0;
        end else begin
            if (w_push) begin
                r_fa[r_wptr]   <= in_a;
                r_fb[r_wptr]   <= in_b;
                r_fop[r_wptr]  <= in_op;
                r_ftag[r_wptr] <= r_tag;
                r_wptr         <= r_wptr + c_AW'(1);
                r_tag          <= r_tag + TAGW'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            r_cnt <= r_cnt + (c_AW+1)'(w_push) - (c_AW+1)'(w_issue);
        end
    end

    // pend marks that alu_r0 holds a real result next cycle; stale r0 from
    // the unreset ALU register is therefore never captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_ptag  <= '0;
            r_rhead <= 1'b0;
            r_rcnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_rd[i] <= '0;
                r_rt[i] <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                r_rz[i] <= 1'b0;
`endif
            end
        end else begin
            r_pend <= w_issue;
            r_ptag <= r_ftag[r_rptr];
            if (r_pend) begin
                r_rd[w_widx] <= alu_r0;
                r_rt[w_widx] <= r_ptag;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                r_rz[w_widx] <= (alu_r0 == '0);
`endif
            end
            if (w_pop) begin
                r_rhead <= ~r_rhead;
            end
            case ({r_pend, w_pop})
                2'b10:   r_rcnt <= r_rcnt + 2'd1;
                2'b01:   r_rcnt <= r_rcnt - 2'd1;
                default: r_rcnt <= r_rcnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
// Module   : tb_alu_issue_queue
// Purpose  : Queue-based reference model with per-cycle output comparison
//            plus directed scenarios with literal expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;

    localparam int N = 32, DEPTH = 4, TAGW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_a = '0, in_b = '0;
    logic [2:0]      in_op = '0;
    logic [N-1:0]    alu_r2, alu_r3;
    logic [2:0]      alu_op;
    logic [N-1:0]    alu_r0 = 32'hDEADBEEF;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [N-1:0]    res_data;
    logic [TAGW-1:0] res_tag;
    logic            busy;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic            res_zero;
`endif

    alu_issue_queue #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_op(alu_op), .alu_r0(alu_r0),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        .res_zero(res_zero),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stage stand-in: unreset output register.
    always @(posedge clk) alu_r0 <= alu_r2 + alu_r3;

    typedef struct packed {
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [2:0]      op;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [N-1:0]    data;
        logic [TAGW-1:0] tag;
        logic            zero;
    } res_t;

    typedef struct {
        logic [N-1:0]    data;
        logic [TAGW-1:0] tag;
        logic            zero;
        int              cyc;
    } log_t;

    req_t mq[$];
    res_t rq[$];
    log_t plog[$];
    bit            m_pend = 0;
    res_t          m_pres;
    logic [TAGW-1:0] m_tag = '0;
    bit            started = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on pre-edge values at each rising edge.
    initial begin
        bit   pop, issue, acc;
        req_t h;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mq.delete(); rq.delete();
                m_pend = 0; m_tag = '0; started = 1;
            end else begin
                pop   = (rq.size() > 0) && res_ready;
                issue = (mq.size() > 0) && (rq.size() + int'(m_pend) - int'(pop) <= 1);
                acc   = in_valid && (mq.size() < DEPTH);
                if (pop) begin
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                    plog.push_back('{res_data, res_tag, res_zero, cyc});
`else
                    plog.push_back('{res_data, res_tag, 1'b0, cyc});
`endif
                    void'(rq.pop_front());
                end
                if (m_pend) rq.push_back(m_pres);
                if (rq.size() > 2) begin
                    n_bad++;
                    $display("FAIL overflow: result buffer holds %0d expected <=2", rq.size());
                end
                if (issue) begin
                    h = mq.pop_front();
                    m_pres.data = h.a + h.b;
                    m_pres.tag  = h.tag;
                    m_pres.zero = ((h.a + h.b) == '0);
                end
                m_pend = issue;
                if (acc) begin
                    mq.push_back('{in_a, in_b, in_op, m_tag});
                    m_tag = m_tag + 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
            chk("alu_r2",    64'(alu_r2),    64'(mq.size() > 0 ? mq[0].a  : '0));
            chk("alu_r3",    64'(alu_r3),    64'(mq.size() > 0 ? mq[0].b  : '0));
            chk("alu_op",    64'(alu_op),    64'(mq.size() > 0 ? mq[0].op : '0));
            chk("res_valid", 64'(res_valid), 64'(rq.size() > 0));
            chk("res_data",  64'(res_data),  64'(rq.size() > 0 ? rq[0].data : '0));
            chk("res_tag",   64'(res_tag),   64'(rq.size() > 0 ? rq[0].tag  : '0));
            chk("busy",      64'(busy),      64'((mq.size() > 0) || m_pend || (rq.size() > 0)));
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            chk("res_zero",  64'(res_zero),  64'(rq.size() > 0 ? rq[0].zero : 1'b0));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        bit ok;
        bit done = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int k = 0; k < 60 && !done; k++) begin
            ok = in_ready;
            tick(1);
            if (ok) done = 1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        // Reset then idle: nothing may be captured from stale r0.
        do_reset();
        tick(5);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_res_valid", 64'(res_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_alu_op", 64'(alu_op), 64'd0);

        // Single op.
        plog.delete();
        push(32'd5, 32'd7, 3'd3);
        chk("single_r2", 64'(alu_r2), 64'd5);
        chk("single_r3", 64'(alu_r3), 64'd7);
        chk("single_op", 64'(alu_op), 64'd3);
        tick(2);
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_data", 64'(res_data), 64'd12);
        chk("single_tag", 64'(res_tag), 64'd0);
        tick(3);

        // Back-to-back with res_ready held high.
        do_reset();
        plog.delete();
        for (int i = 1; i <= 4; i++) push(N'(i), N'(i), 3'(i));
        tick(6);
        chk("b2b_count", 64'(plog.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (plog.size() > k) begin
                chk("b2b_data", 64'(plog[k].data), 64'(2 * (k + 1)));
                chk("b2b_tag",  64'(plog[k].tag),  64'(k));
                chk("b2b_cyc",  64'(plog[k].cyc),  64'(plog[0].cyc + k));
            end
        end

        // Backpressure: 6 accepted (2 buffered + 4 queued), 7th held off.
        do_reset();
        plog.delete();
        res_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(N'(i), N'(i), 3'd0);
        tick(3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        chk("bp_head", 64'(res_data), 64'd2);
        chk("bp_alu_r2", 64'(alu_r2), 64'd3);
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd7;
        tick(3);
        chk("bp_held", 64'(in_ready), 64'd0);
        res_ready = 1'b1;
        push(32'd7, 32'd7, 3'd0);
        tick(12);
        chk("bp_count", 64'(plog.size()), 64'd7);
        for (int k = 0; k < 7; k++) begin
            if (plog.size() > k) begin
                chk("bp_data", 64'(plog[k].data), 64'(2 * (k + 1)));
                chk("bp_tag",  64'(plog[k].tag),  64'(k));
            end
        end

        // Tag wrap.
        do_reset();
        plog.delete();
        for (int i = 0; i < 18; i++) begin
            push(N'(i), 32'd1, 3'd1);
            tick(3);
        end
        chk("wrap_count", 64'(plog.size()), 64'd18);
        for (int k = 0; k < 18; k++) begin
            if (plog.size() > k) begin
                chk("wrap_tag",  64'(plog[k].tag),  64'(k % 16));
                chk("wrap_data", 64'(plog[k].data), 64'(k + 1));
            end
        end

        // Mid-operation reset.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'd100, N'(i), 3'd2);
        in_valid = 1'b1;
        do_reset();
        chk("mr_res_valid", 64'(res_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_busy", 64'(busy), 64'd0);
        res_ready = 1'b1;
        plog.delete();
        push(32'd9, 32'd1, 3'd4);
        tick(4);
        chk("mr_count", 64'(plog.size()), 64'd1);
        if (plog.size() > 0) begin
            chk("mr_tag", 64'(plog[0].tag), 64'd0);
            chk("mr_data", 64'(plog[0].data), 64'd10);
        end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        push(32'd0, 32'd0, 3'd0);
        tick(2);
        chk("zf_valid", 64'(res_valid), 64'd1);
        chk("zf_zero", 64'(res_zero), 64'd1);
        chk("zf_data", 64'(res_data), 64'd0);
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
